// File: rtl/shift_normalizer_if.sv
// Handshake and result bundle between the CPU control (master) and the
// leading-fill normalizer unit (slave).
interface shift_normalizer_if;
  logic        start;
  logic        mode;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] norm;
  logic        all_fill;

  modport master (
    output start, mode, data_in,
    input  busy, done, count, norm, all_fill
  );

  modport slave (
    input  start, mode, data_in,
    output busy, done, count, norm, all_fill
  );
endinterface

// File: rtl/shift_normalizer.sv
// Multi-cycle CLZ/CLO unit: binary search over 16/8/4/2/1-bit steps, one step
// per cycle, returning the leading-fill count and the left-normalized operand.
module shift_normalizer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  shift_normalizer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] w_reg;
  logic             f_reg;
  logic [5:0]       c_reg;
  logic [4:0]       k_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [5:0]       count_reg;
  logic [WIDTH-1:0] norm_reg;
  logic             all_fill_reg;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] fill_word;
  logic             match;
  logic [WIDTH-1:0] step_w;
  logic [5:0]       step_c;

  // Top k bits of W are compared against the fill bit in one masked XOR.
  always_comb begin
    mask      = ~({WIDTH{1'b1}} >> k_reg);
    fill_word = {WIDTH{f_reg}};
    match     = ((w_reg ^ fill_word) & mask) == '0;
    step_w    = match ? (w_reg << k_reg) : w_reg;
    step_c    = match ? (c_reg + 6'(k_reg)) : c_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      w_reg        <= '0;
      f_reg        <= 1'b0;
      c_reg        <= '0;
      k_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      count_reg    <= '0;
      norm_reg     <= '0;
      all_fill_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            w_reg     <= bus.data_in;
            f_reg     <= bus.mode;
            c_reg     <= '0;
            k_reg     <= 5'd16;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            state_reg <= RUN;
          end else begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (k_reg == 5'd1) begin
            // The search reaches at most 31; a still-matching MSB means all 32 bits are fill.
            if (step_w[WIDTH-1] == f_reg) begin
              count_reg    <= step_c + 6'd1;
              norm_reg     <= step_w << 1;
              all_fill_reg <= 1'b1;
            end else begin
              count_reg    <= step_c;
              norm_reg     <= step_w;
              all_fill_reg <= 1'b0;
            end
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            w_reg <= step_w;
            c_reg <= step_c;
            k_reg <= k_reg >> 1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.count    = count_reg;
  assign bus.norm     = norm_reg;
  assign bus.all_fill = all_fill_reg;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed plus randomized bench for shift_normalizer against a bit-scan
// reference model of the leading-fill count.
module tb_shift_normalizer;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [5:0]  prev_count    = '0;
  logic [31:0] prev_norm     = '0;
  logic        prev_all_fill = 1'b0;

  shift_normalizer_if bus ();

  shift_normalizer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scan from the MSB counting bits equal to the fill bit.
  function automatic void model(input logic [31:0] d, input logic m,
                                output logic [5:0] c, output logic [31:0] n,
                                output logic af);
    int cnt;
    cnt = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] == m) cnt++;
      else break;
    end
    c  = 6'(cnt);
    n  = (cnt == 32) ? 32'h0 : (d << cnt);
    af = (cnt == 32);
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_count"}, bus.count, prev_count);
    check({tag, "_norm"}, bus.norm, prev_norm);
    check({tag, "_all_fill"}, bus.all_fill, prev_all_fill);
  endtask

  // Called just after a falling edge; drives start so the next rising edge accepts it.
  task automatic run_op(input logic [31:0] d, input logic m, input bit noise, input bit b2b);
    logic [5:0]  ec;
    logic [31:0] en;
    logic        ea;
    model(d, m, ec, en, ea);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.mode    = m;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("busy_run", bus.busy, 1);
      check("done_run", bus.done, 0);
      check_held("hold_run");
      if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.data_in = $urandom;
        bus.mode    = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_pulse", bus.done, 1);
    check("busy_done", bus.busy, 0);
    check("count", bus.count, ec);
    check("norm", bus.norm, en);
    check("all_fill", bus.all_fill, ea);
    $display("op data=%08h mode=%0d -> count=%0d norm=%08h all_fill=%0d (ref %0d %08h %0d)",
             d, m, bus.count, bus.norm, bus.all_fill, ec, en, ea);
    prev_count    = ec;
    prev_norm     = en;
    prev_all_fill = ea;
    if (!b2b) begin
      bus.start = 1'b0;
      @(negedge clk);
      check("done_drop", bus.done, 0);
      check("busy_idle", bus.busy, 0);
      check_held("hold_idle");
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        m;
    bit          b2b;

    reset       = 1'b0;
    bus.start   = 1'b1;
    bus.mode    = 1'b0;
    bus.data_in = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.count, 0);
    check("rst_norm", bus.norm, 0);
    check("rst_all_fill", bus.all_fill, 0);
    $display("reset held 2 cycles with start=1");

    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
    end

    run_op(32'h00010000, 1'b0, 1'b0, 1'b0);
    run_op(32'h80000000, 1'b0, 1'b0, 1'b0);
    run_op(32'h00000000, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op(32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    run_op(32'h00000001, 1'b0, 1'b0, 1'b0);

    // Abort a search on its third RUN cycle.
    bus.start   = 1'b1;
    bus.data_in = 32'h00F00000;
    bus.mode    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_norm", bus.norm, 0);
    check("midrst_all_fill", bus.all_fill, 0);
    $display("reset asserted mid-search on data=00f00000");
    reset         = 1'b1;
    prev_count    = '0;
    prev_norm     = '0;
    prev_all_fill = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_done", bus.done, 0);
      check("midrst_no_busy", bus.busy, 0);
    end
    run_op(32'h00F00000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      d = d >> $urandom_range(0, 32);
      m = 1'($urandom_range(0, 1));
      if (m) d = ~d;
      b2b = (i < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
      run_op(d, m, bit'($urandom_range(0, 1)), b2b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
Sequential normalizer that recovers the shift amount from a shifted operand, i.e. the inverse of the ALU barrel shifter. It counts leading zeros (CLZ) or leading ones (CLO) of a 32-bit operand and returns the count and the left-normalized value. The search is binary over 16/8/4/2/1-bit steps, one step per cycle. It sits beside the ALU as a multi-cycle functional unit that the CPU control starts and polls via a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; only 32 is supported and the count width is fixed at 6.

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only when the unit is not busy
mode  input  1  0 = CLZ (fill bit 0), 1 = CLO (fill bit 1)
data_in  input  32  operand; sampled on the edge that accepts start
busy  output  1  high while a search is in progress
done  output  1  one-cycle pulse when results become valid
count  output  6  number of leading fill bits, range 0..32
norm  output  32  data_in shifted left by count, with zero fill from the right
all_fill  output  1  high when every bit of the operand equals the fill bit (count = 32)

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state goes to IDLE.
  - busy, done, count, norm and all_fill all become 0.
  - Reset has priority over all other inputs, including mid-search; the partial result is discarded.
- States are IDLE, RUN and DONE.
  - IDLE or DONE with start = 1 at an edge: latch data_in into working register W, mode into fill bit F, clear the internal count C, set step k = 16. Go to RUN with busy = 1 and done = 0.
  - IDLE or DONE with start = 0: stay in the current state. From DONE, go to IDLE at the next edge with done = 0; outputs hold.
  - RUN, one step per edge, k in the sequence 16, 8, 4, 2, 1:
    - If W[31:32-k] are all equal to F, then W <= W << k (zero fill) and C <= C + k.
    - Otherwise W and C are unchanged.
  - RUN, on the edge that executes the k = 1 step:
    - Apply the final correction to the step-1 result: if the resulting W[31] still equals F, the result is C+1 = 32, norm = W << 1, and all_fill = 1; otherwise all_fill = 0.
    - Register count and norm.
    - Go to DONE with done = 1 and busy = 0.
- Latency:
  - If start is accepted at edge E0, done is high for exactly the cycle after edge E0+5.
  - busy is high for the 5 cycles following E0.
- start while busy is ignored; it is neither queued nor allowed to alter the operand.
- start asserted during the DONE cycle is accepted: back-to-back operation with no idle gap, so done drops and busy rises at that edge.
- count, norm and all_fill hold their last result until the next completion or reset; they do not change during RUN.
- For an all-fill operand, norm is all zeros, since every original bit is shifted out in both modes.
- count + (index of first non-fill bit from the MSB) is consistent, and norm[31] = ~F whenever all_fill = 0.

Test Plan:
1. Reset: hold reset = 0 for 2 cycles with start = 1 -> busy = done = all_fill = 0, count = 0, norm = 0; the unit stays in IDLE after reset is released with start = 0.
2. CLZ with mid-word and trivial operands:
   - start = 1, mode = 0, data_in = 0x00010000 -> done pulses 5 cycles after the start edge with count = 15, norm = 0x80000000, all_fill = 0.
   - data_in = 0x80000000 -> count = 0, norm = 0x80000000.
3. All-fill boundaries:
   - mode = 0, data_in = 0x00000000 -> count = 32, norm = 0, all_fill = 1.
   - mode = 1, data_in = 0xFFFFFFFF -> count = 32, norm = 0, all_fill = 1.
4. CLO:
   - mode = 1, data_in = 0xFFFFFFF0 -> count = 28, norm = 0x00000000, all_fill = 0.
   - data_in = 0x7FFFFFFF -> count = 0, norm = 0x7FFFFFFF.
5. Handshake:
   - Assert start with a new data_in during the busy cycles -> ignored, the first result is unchanged.
   - Assert start in the DONE cycle with data_in = 0x00000001, mode = 0 -> accepted immediately; the second done arrives 5 cycles later with count = 31, norm = 0x80000000.
6. Reset mid-operation: pull reset low on the 3rd RUN cycle -> busy, done, count, norm and all_fill are 0 next cycle and no done pulse occurs. A fresh start afterwards completes normally with full 5-cycle latency.
